input_conditioner: RTL and testbench

Board-input front end for the DE-series demo designs: synchronizes and debounces the raw pushbuttons (KEY, active-low) and slide switches (SW), and produces clean levels plus single-cycle press/release/change strobes for downstream display and control logic. It sits between the top-level board pins and user logic, and is the input-side counterpart to the LED/HEX output path. All inputs are processed independently with identical per-bit logic.

---
 rtl/input_conditioner.sv | 142 ++++++++++++++
 tb/tb_input_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Board-input front end: 2-flop sync, debounce and edge strobes for KEY (active-low) and SW.
// Optional per-key auto-repeat on KEY_PRESS when KEY_AUTOREPEAT_EN is defined.
module input_conditioner #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned RPT_DELAY = 25000000,
  parameter int unsigned RPT_RATE  = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [3:0] KEY_DB,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [9:0] SW_DB,
  output logic       SW_CHG
);

  localparam int unsigned N_KEY = 4;
  localparam int unsigned N_SW  = 10;
  localparam int unsigned N_IN  = N_KEY + N_SW;
  localparam int unsigned CW    = $clog2(DB_CYCLES);
  // Keys idle high (released), switches idle low.
  localparam logic [N_IN-1:0] RST_VAL = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

  if (DB_CYCLES < 2 || RPT_DELAY < 2 || RPT_RATE < 2) begin : g_param_check
    $error("input_conditioner: DB_CYCLES, RPT_DELAY and RPT_RATE must be >= 2");
  end

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  commit;
  logic [CW-1:0]    cnt [N_IN];
  logic [N_KEY-1:0] rpt_hit;
  logic [N_KEY-1:0] key_press_q;
  logic [N_KEY-1:0] key_release_q;
  logic             sw_chg_q;

  assign raw = {SW, KEY};

  // Two-flop synchronizer for every raw input bit.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A bit commits on the last of DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    commit = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      commit[i] = (sync2[i] != stable[i]) && (cnt[i] == CW'(DB_CYCLES - 1));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      stable <= RST_VAL;
      for (int i = 0; i < int'(N_IN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Strobes are registered on the commit edge so they line up with the new level.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      key_press_q   <= '0;
      key_release_q <= '0;
      sw_chg_q      <= 1'b0;
    end else begin
      key_press_q   <= (commit[N_KEY-1:0] & ~sync2[N_KEY-1:0]) | rpt_hit;
      key_release_q <= commit[N_KEY-1:0] & sync2[N_KEY-1:0];
      sw_chg_q      <= |commit[N_IN-1:N_KEY];
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int unsigned RW      = $clog2(RPT_MAX);

  logic [RW-1:0]    rpt_cnt [N_KEY];
  logic [N_KEY-1:0] rpt_phase;

  // Phase 0 waits RPT_DELAY after the press strobe, phase 1 repeats every RPT_RATE.
  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < int'(N_KEY); i++) begin
      rpt_hit[i] = KEY_DB[i] && !commit[i] &&
                   (rpt_phase[i] ? (rpt_cnt[i] == RW'(RPT_RATE - 1))
                                 : (rpt_cnt[i] == RW'(RPT_DELAY - 1)));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      rpt_phase <= '0;
      for (int i = 0; i < int'(N_KEY); i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_KEY); i++) begin
        if (!KEY_DB[i] || commit[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (rpt_hit[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign rpt_hit = '0;
`endif

  assign KEY_DB      = ~stable[N_KEY-1:0];
  assign SW_DB       = stable[N_IN-1:N_KEY];
  assign KEY_PRESS   = key_press_q;
  assign KEY_RELEASE = key_release_q;
  assign SW_CHG      = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (DB_CYCLES=8, RPT_DELAY=20, RPT_RATE=5).
module tb_input_conditioner;

  logic       CLOCK_50;
  logic       Resetn;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [3:0] KEY_DB;
  logic [3:0] KEY_PRESS;
  logic [3:0] KEY_RELEASE;
  logic [9:0] SW_DB;
  logic       SW_CHG;

  int checks;
  int failures;
  int press_cnt [4];
  int rel_cnt [4];
  int chg_cnt;

  input_conditioner #(
    .DB_CYCLES(8),
    .RPT_DELAY(20),
    .RPT_RATE (5)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .KEY        (KEY),
    .SW         (SW),
    .KEY_DB     (KEY_DB),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .SW_DB      (SW_DB),
    .SW_CHG     (SW_CHG)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and tally strobes.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] += int'(KEY_PRESS[i]);
      rel_cnt[i]   += int'(KEY_RELEASE[i]);
    end
    chg_cnt += int'(SW_CHG);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    chg_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_db"}, 32'(KEY_DB), 32'h0);
    check({tag, "_press"}, 32'(KEY_PRESS), 32'h0);
    check({tag, "_release"}, 32'(KEY_RELEASE), 32'h0);
    check({tag, "_sw_db"}, 32'(SW_DB), 32'h0);
    check({tag, "_sw_chg"}, 32'(SW_CHG), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_counts();
    Resetn = 1'b0;
    KEY    = 4'hF;
    SW     = 10'h000;

    // Reset state and quiet period after release.
    run(3);
    check_all_zero("rst");
    Resetn = 1'b1;
    clear_counts();
    run(30);
    check_all_zero("idle30");
    check("idle_press_cnt", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
    check("idle_chg_cnt", 32'(chg_cnt), 32'd0);

    // Clean press/release of KEY[0]: level and strobe at edge N+9.
    KEY = 4'hE;
    run(9);
    check("press0_early_db", 32'(KEY_DB), 32'h0);
    check("press0_early_strobe", 32'(KEY_PRESS), 32'h0);
    step();
    check("press0_db", 32'(KEY_DB), 32'h1);
    check("press0_strobe", 32'(KEY_PRESS), 32'h1);
    step();
    check("press0_strobe_end", 32'(KEY_PRESS), 32'h0);
    check("press0_db_hold", 32'(KEY_DB), 32'h1);
    KEY = 4'hF;
    run(9);
    check("rel0_early_db", 32'(KEY_DB), 32'h1);
    step();
    check("rel0_db", 32'(KEY_DB), 32'h0);
    check("rel0_strobe", 32'(KEY_RELEASE), 32'h1);
    step();
    check("rel0_strobe_end", 32'(KEY_RELEASE), 32'h0);

    // Bounce on KEY[1]: toggle every 3 cycles for 40 cycles, then settle low.
    clear_counts();
    for (int t = 0; t < 40; t++) begin
      if (t % 3 == 0) KEY[1] = ~KEY[1];
      step();
    end
    check("bounce_press_cnt", 32'(press_cnt[1]), 32'd0);
    check("bounce_db", 32'(KEY_DB), 32'h0);
    KEY[1] = 1'b0;
    run(9);
    check("settle1_early_db", 32'(KEY_DB), 32'h0);
    step();
    check("settle1_db", 32'(KEY_DB), 32'h2);
    check("settle1_strobe", 32'(KEY_PRESS), 32'h2);
    KEY = 4'hF;
    run(12);
    check("settle1_press_total", 32'(press_cnt[1]), 32'd1);
    check("settle1_release_total", 32'(rel_cnt[1]), 32'd1);
    check("settle1_released", 32'(KEY_DB), 32'h0);

    // Switch load: one SW_CHG pulse, then a short glitch is ignored.
    clear_counts();
    SW = 10'h201;
    run(9);
    check("sw_early", 32'(SW_DB), 32'h0);
    step();
    check("sw_db", 32'(SW_DB), 32'h201);
    check("sw_chg", 32'(SW_CHG), 32'h1);
    step();
    check("sw_chg_end", 32'(SW_CHG), 32'h0);
    SW[0] = 1'b0;
    run(5);
    SW[0] = 1'b1;
    run(20);
    check("sw_glitch_db", 32'(SW_DB), 32'h201);
    check("sw_chg_cnt", 32'(chg_cnt), 32'd1);

    // Simultaneous press of KEY[2] and KEY[3].
    clear_counts();
    KEY = 4'h3;
    run(9);
    check("simul_early", 32'(KEY_PRESS), 32'h0);
    step();
    check("simul_press", 32'(KEY_PRESS), 32'hC);
    check("simul_db", 32'(KEY_DB), 32'hC);
    KEY = 4'hF;
    run(15);
    check("simul_released", 32'(KEY_DB), 32'h0);
    check("simul_rel_cnt", 32'(rel_cnt[2] + rel_cnt[3]), 32'd2);

    // Reset mid-count: outputs clear at once, full debounce needed afterwards.
    KEY = 4'hE;
    run(5);
    Resetn = 1'b0;
    #1;
    check("midrst_sw_db", 32'(SW_DB), 32'h0);
    check("midrst_key_db", 32'(KEY_DB), 32'h0);
    run(2);
    Resetn = 1'b1;
    clear_counts();
    run(9);
    check("postrst_key_db_early", 32'(KEY_DB), 32'h0);
    check("postrst_sw_db_early", 32'(SW_DB), 32'h0);
    check("postrst_no_strobe", 32'(press_cnt[0] + chg_cnt), 32'd0);
    step();
    check("postrst_key_db", 32'(KEY_DB), 32'h1);
    check("postrst_press", 32'(KEY_PRESS), 32'h1);
    check("postrst_sw_db", 32'(SW_DB), 32'h201);
    check("postrst_sw_chg", 32'(SW_CHG), 32'h1);

    // Hold KEY[0] for 60 cycles past the press strobe.
    clear_counts();
    run(60);
`ifdef KEY_AUTOREPEAT_EN
    check("hold_repeat_cnt", 32'(press_cnt[0]), 32'd9);
`else
    check("hold_repeat_cnt", 32'(press_cnt[0]), 32'd0);
`endif
    check("hold_db", 32'(KEY_DB), 32'h1);
    KEY = 4'hF;
    run(15);
    check("hold_released", 32'(KEY_DB), 32'h0);
    check("hold_rel_cnt", 32'(rel_cnt[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
